// File: rtl/crypt_uart_pkg.sv
// crypt_uart_pkg
// Constants and types shared by the receive-side word packer and the
// transmit-side word splitter of the crypto UART path.
//   BYTES_PER_WORD          bytes per 32-bit crypto word
//   DEFAULT_TIMEOUT_CYCLES  default inter-byte idle limit, in clk cycles
//   asm_state_e             word assembly state
package crypt_uart_pkg;

    localparam int unsigned BYTES_PER_WORD         = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 20000;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        ASSEMBLE = 1'b1
    } asm_state_e;

endpackage

// File: rtl/uart_word_packer_if.sv
// uart_word_packer_if
// Byte stream from the UART receiver plus the word handshake toward the
// crypto datapath, bundled so the packer takes a single bus port.
//   master : the surroundings (byte receiver and word consumer)
//   slave  : the word packer
//   Data_Rx / Data_Ready / parity_err      byte stream into the packer
//   Final_Data / Final_Data_Ready          assembled word out of the packer
//   Final_Data_Ack                         consumer acceptance
interface uart_word_packer_if;

    logic [7:0]  Data_Rx;
    logic        Data_Ready;
    logic        parity_err;
    logic [31:0] Final_Data;
    logic        Final_Data_Ready;
    logic        Final_Data_Ack;

    modport master (
        output Data_Rx,
        output Data_Ready,
        output parity_err,
        output Final_Data_Ack,
        input  Final_Data,
        input  Final_Data_Ready
    );

    modport slave (
        input  Data_Rx,
        input  Data_Ready,
        input  parity_err,
        input  Final_Data_Ack,
        output Final_Data,
        output Final_Data_Ready
    );

endinterface

// File: rtl/uart_word_packer_idle_timer.sv
// idle_timer
// Counts idle cycles between bytes of a partial word.
//   clk        system clock
//   rst        synchronous active-high reset
//   load_zero  force the count to 0 (byte seen, or no partial word)
//   enable     advance the count this cycle
//   expire     high in the cycle the count sits at TIMEOUT_CYCLES-1 while
//              enabled; the owner drops the partial word on the next edge
module idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_zero,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expire = enable && (cnt == TERM);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load_zero || expire) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_word_packer.sv
// uart_word_packer
// Packs four consecutive good UART bytes, first byte in [31:24], into a
// 32-bit word and offers it on a valid/ack handshake. Partial words are
// dropped on a parity error or an inter-byte timeout; a completed word that
// finds the output still occupied is dropped and reported as an overrun.
//   CLK           system clock, rising edge
//   CLR           synchronous active-high reset
//   bus           byte stream in, word handshake out (slave side)
//   Byte_Count    bytes held in the partial word (0-3)
//   Err_Parity    1-cycle pulse: partial word dropped on parity error
//   Err_Timeout   1-cycle pulse: partial word dropped on idle timeout
//   Overrun       1-cycle pulse: completed word dropped, output occupied
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | no partial word, Byte_Count = 0, timer held at 0
// ASSEMBLE  | 1-3 bytes held, idle timer running between bytes
module uart_word_packer
    import crypt_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  CLR,
    uart_word_packer_if.slave     bus,
    output logic [1:0]            Byte_Count,
    output logic                  Err_Parity,
    output logic                  Err_Timeout,
    output logic                  Overrun
);

    localparam logic [0:0] ST_IDLE     = IDLE;
    localparam logic [0:0] ST_ASSEMBLE = ASSEMBLE;
    localparam logic [1:0] LAST_IDX    = 2'(BYTES_PER_WORD - 1);

    logic [0:0]  state;
    logic [1:0]  count;
    // Only three bytes are ever held; the fourth goes straight to the output.
    logic [23:0] shreg;

    logic        good_byte;
    logic        bad_byte;
    logic        word_done;
    logic        out_free;
    logic        timer_load;
    logic        timer_en;
    logic        timer_expire;

    assign good_byte  = bus.Data_Ready && !bus.parity_err;
    assign bad_byte   = bus.Data_Ready &&  bus.parity_err;
    assign word_done  = good_byte && (count == LAST_IDX);
    // An ack in the same cycle frees the slot for the incoming word.
    assign out_free   = !bus.Final_Data_Ready || bus.Final_Data_Ack;

    assign timer_load = bus.Data_Ready || (state == ST_IDLE);
    // A byte in the expiry cycle suppresses the timeout.
    assign timer_en   = (state == ST_ASSEMBLE) && !bus.Data_Ready;

    assign Byte_Count = count;

    idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk       (CLK),
        .rst       (CLR),
        .load_zero (timer_load),
        .enable    (timer_en),
        .expire    (timer_expire)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state       <= ST_IDLE;
            count       <= 2'd0;
            shreg       <= 24'h0;
            Err_Parity  <= 1'b0;
            Err_Timeout <= 1'b0;
        end else begin
            Err_Parity  <= 1'b0;
            Err_Timeout <= 1'b0;
            if (bad_byte) begin
                state      <= ST_IDLE;
                count      <= 2'd0;
                Err_Parity <= 1'b1;
            end else if (good_byte) begin
                shreg <= {shreg[15:0], bus.Data_Rx};
                count <= count + 2'd1;
                state <= (count == LAST_IDX) ? ST_IDLE : ST_ASSEMBLE;
            end else if (timer_expire) begin
                state       <= ST_IDLE;
                count       <= 2'd0;
                Err_Timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            bus.Final_Data       <= 32'h0;
            bus.Final_Data_Ready <= 1'b0;
            Overrun              <= 1'b0;
        end else begin
            Overrun <= 1'b0;
            if (word_done && out_free) begin
                bus.Final_Data       <= {shreg, bus.Data_Rx};
                bus.Final_Data_Ready <= 1'b1;
            end else begin
                if (word_done) begin
                    Overrun <= 1'b1;
                end
                if (bus.Final_Data_Ready && bus.Final_Data_Ack) begin
                    bus.Final_Data_Ready <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_word_packer.sv
module tb_uart_word_packer;

    logic clk;
    logic clr;
    int   n_vec;
    int   n_err;

    uart_word_packer_if ifa ();
    uart_word_packer_if ifb ();

    logic [1:0] cnt_a, cnt_b;
    logic       ep_a, et_a, ov_a;
    logic       ep_b, et_b, ov_b;

    // Default timeout for the long-spaced tests, short timeout for timer tests.
    uart_word_packer dut_a (
        .CLK         (clk),
        .CLR         (clr),
        .bus         (ifa),
        .Byte_Count  (cnt_a),
        .Err_Parity  (ep_a),
        .Err_Timeout (et_a),
        .Overrun     (ov_a)
    );

    uart_word_packer #(.TIMEOUT_CYCLES(50)) dut_b (
        .CLK         (clk),
        .CLR         (clr),
        .bus         (ifb),
        .Byte_Count  (cnt_b),
        .Err_Parity  (ep_b),
        .Err_Timeout (et_b),
        .Overrun     (ov_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input logic perr);
        if (!sel) begin
            ifa.Data_Rx = b; ifa.parity_err = perr; ifa.Data_Ready = 1'b1;
        end else begin
            ifb.Data_Rx = b; ifb.parity_err = perr; ifb.Data_Ready = 1'b1;
        end
        @(posedge clk); #1;
        ifa.Data_Ready = 1'b0; ifa.parity_err = 1'b0;
        ifb.Data_Ready = 1'b0; ifb.parity_err = 1'b0;
    endtask

    task automatic ack(input bit sel);
        if (!sel) ifa.Final_Data_Ack = 1'b1; else ifb.Final_Data_Ack = 1'b1;
        @(posedge clk); #1;
        ifa.Final_Data_Ack = 1'b0;
        ifb.Final_Data_Ack = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        idle(5);
        clr = 1'b0;
        n_vec++;
        if (ifa.Final_Data !== 32'h0 || ifa.Final_Data_Ready !== 1'b0 || cnt_a !== 2'd0) begin
            n_err++;
            $display("FAIL reset_a: data=%h rdy=%b cnt=%0d expected data=0 rdy=0 cnt=0",
                     ifa.Final_Data, ifa.Final_Data_Ready, cnt_a);
        end
        n_vec++;
        if ({ep_a, et_a, ov_a, ep_b, et_b, ov_b} !== 6'b0 || ifb.Final_Data_Ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: pulses=%b rdy_b=%b expected 000000/0",
                     {ep_a, et_a, ov_a, ep_b, et_b, ov_b}, ifb.Final_Data_Ready);
        end
    endtask

    task automatic test_normal_word();
        logic [7:0] bytes [4];
        logic [1:0] exp_cnt [4];
        bytes   = '{8'hAB, 8'hAC, 8'hAD, 8'hAE};
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            if (i != 0) idle(99);
            send(1'b0, bytes[i], 1'b0);
            n_vec++;
            if (cnt_a !== exp_cnt[i]) begin
                n_err++;
                $display("FAIL normal_count[%0d]: got %0d expected %0d", i, cnt_a, exp_cnt[i]);
            end
        end
        n_vec++;
        if (ifa.Final_Data_Ready !== 1'b1 || ifa.Final_Data !== 32'hABACADAE) begin
            n_err++;
            $display("FAIL normal_word: rdy=%b data=%h expected rdy=1 data=abacadae",
                     ifa.Final_Data_Ready, ifa.Final_Data);
        end
        idle(5);
        n_vec++;
        if (ifa.Final_Data_Ready !== 1'b1) begin
            n_err++;
            $display("FAIL normal_hold: rdy=%b expected 1", ifa.Final_Data_Ready);
        end
        ack(1'b0);
        n_vec++;
        if (ifa.Final_Data_Ready !== 1'b0 || ifa.Final_Data !== 32'hABACADAE) begin
            n_err++;
            $display("FAIL normal_ack: rdy=%b data=%h expected rdy=0 data=abacadae",
                     ifa.Final_Data_Ready, ifa.Final_Data);
        end
    endtask

    task automatic test_parity_drop();
        send(1'b0, 8'hAB, 1'b0);
        send(1'b0, 8'hAC, 1'b0);
        send(1'b0, 8'hCD, 1'b1);
        n_vec++;
        if (ep_a !== 1'b1 || cnt_a !== 2'd0) begin
            n_err++;
            $display("FAIL parity_pulse: err=%b cnt=%0d expected err=1 cnt=0", ep_a, cnt_a);
        end
        idle(1);
        n_vec++;
        if (ep_a !== 1'b0) begin
            n_err++;
            $display("FAIL parity_width: err=%b expected 0", ep_a);
        end
        send(1'b0, 8'h11, 1'b0);
        send(1'b0, 8'h22, 1'b0);
        send(1'b0, 8'h33, 1'b0);
        send(1'b0, 8'h44, 1'b0);
        n_vec++;
        if (ifa.Final_Data_Ready !== 1'b1 || ifa.Final_Data !== 32'h11223344) begin
            n_err++;
            $display("FAIL parity_word: rdy=%b data=%h expected rdy=1 data=11223344",
                     ifa.Final_Data_Ready, ifa.Final_Data);
        end
        ack(1'b0);
    endtask

    task automatic test_timeout();
        send(1'b1, 8'hAB, 1'b0);
        send(1'b1, 8'hAC, 1'b0);
        idle(49);
        n_vec++;
        if (et_b !== 1'b0 || cnt_b !== 2'd2) begin
            n_err++;
            $display("FAIL timeout_early: err=%b cnt=%0d expected err=0 cnt=2", et_b, cnt_b);
        end
        idle(1);
        n_vec++;
        if (et_b !== 1'b1 || cnt_b !== 2'd0) begin
            n_err++;
            $display("FAIL timeout_pulse: err=%b cnt=%0d expected err=1 cnt=0", et_b, cnt_b);
        end
        idle(1);
        n_vec++;
        if (et_b !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_width: err=%b expected 0", et_b);
        end
        idle(8);
        send(1'b1, 8'h01, 1'b0);
        send(1'b1, 8'h02, 1'b0);
        send(1'b1, 8'h03, 1'b0);
        send(1'b1, 8'h04, 1'b0);
        n_vec++;
        if (ifb.Final_Data_Ready !== 1'b1 || ifb.Final_Data !== 32'h01020304) begin
            n_err++;
            $display("FAIL timeout_word: rdy=%b data=%h expected rdy=1 data=01020304",
                     ifb.Final_Data_Ready, ifb.Final_Data);
        end
        ack(1'b1);
    endtask

    task automatic test_timeout_boundary();
        send(1'b1, 8'hAB, 1'b0);
        send(1'b1, 8'hAC, 1'b0);
        idle(49);
        send(1'b1, 8'h5A, 1'b0);
        n_vec++;
        if (et_b !== 1'b0 || cnt_b !== 2'd3) begin
            n_err++;
            $display("FAIL boundary_byte: err=%b cnt=%0d expected err=0 cnt=3", et_b, cnt_b);
        end
        idle(49);
        send(1'b1, 8'h5B, 1'b0);
        n_vec++;
        if (et_b !== 1'b0 || ifb.Final_Data_Ready !== 1'b1 || ifb.Final_Data !== 32'hABAC5A5B) begin
            n_err++;
            $display("FAIL boundary_word: err=%b rdy=%b data=%h expected err=0 rdy=1 data=abac5a5b",
                     et_b, ifb.Final_Data_Ready, ifb.Final_Data);
        end
        ack(1'b1);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 4; i++) send(1'b0, 8'(i), 1'b0);
        n_vec++;
        if (ifa.Final_Data_Ready !== 1'b1 || ifa.Final_Data !== 32'h00010203) begin
            n_err++;
            $display("FAIL overrun_first: rdy=%b data=%h expected rdy=1 data=00010203",
                     ifa.Final_Data_Ready, ifa.Final_Data);
        end
        for (int i = 4; i < 7; i++) send(1'b0, 8'(i), 1'b0);
        n_vec++;
        if (ov_a !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_early: ov=%b expected 0", ov_a);
        end
        send(1'b0, 8'h07, 1'b0);
        n_vec++;
        if (ov_a !== 1'b1 || ifa.Final_Data !== 32'h00010203 || ifa.Final_Data_Ready !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_pulse: ov=%b data=%h rdy=%b expected ov=1 data=00010203 rdy=1",
                     ov_a, ifa.Final_Data, ifa.Final_Data_Ready);
        end
        idle(1);
        n_vec++;
        if (ov_a !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_width: ov=%b expected 0", ov_a);
        end
    endtask

    task automatic test_same_cycle_ack();
        send(1'b0, 8'h10, 1'b0);
        send(1'b0, 8'h11, 1'b0);
        send(1'b0, 8'h12, 1'b0);
        ifa.Data_Rx = 8'h13; ifa.parity_err = 1'b0; ifa.Data_Ready = 1'b1;
        ifa.Final_Data_Ack = 1'b1;
        @(posedge clk); #1;
        ifa.Data_Ready = 1'b0; ifa.Final_Data_Ack = 1'b0;
        n_vec++;
        if (ifa.Final_Data_Ready !== 1'b1 || ifa.Final_Data !== 32'h10111213 || ov_a !== 1'b0) begin
            n_err++;
            $display("FAIL same_cycle: rdy=%b data=%h ov=%b expected rdy=1 data=10111213 ov=0",
                     ifa.Final_Data_Ready, ifa.Final_Data, ov_a);
        end
        ack(1'b0);
        n_vec++;
        if (ifa.Final_Data_Ready !== 1'b0 || ifa.Final_Data !== 32'h10111213) begin
            n_err++;
            $display("FAIL same_cycle_ack: rdy=%b data=%h expected rdy=0 data=10111213",
                     ifa.Final_Data_Ready, ifa.Final_Data);
        end
    endtask

    task automatic test_ack_idle();
        ack(1'b0);
        n_vec++;
        if (ifa.Final_Data_Ready !== 1'b0) begin
            n_err++;
            $display("FAIL ack_idle: rdy=%b expected 0", ifa.Final_Data_Ready);
        end
        send(1'b0, 8'h21, 1'b0);
        send(1'b0, 8'h22, 1'b0);
        send(1'b0, 8'h23, 1'b0);
        send(1'b0, 8'h24, 1'b0);
        n_vec++;
        if (ifa.Final_Data_Ready !== 1'b1 || ifa.Final_Data !== 32'h21222324 || ov_a !== 1'b0) begin
            n_err++;
            $display("FAIL ack_idle_word: rdy=%b data=%h ov=%b expected rdy=1 data=21222324 ov=0",
                     ifa.Final_Data_Ready, ifa.Final_Data, ov_a);
        end
    endtask

    task automatic test_reset_mid_word();
        logic err_seen;
        logic [7:0] bytes [4];
        bytes = '{8'h10, 8'h20, 8'h30, 8'h40};
        send(1'b0, 8'hAB, 1'b0);
        send(1'b0, 8'hAC, 1'b0);
        n_vec++;
        if (cnt_a !== 2'd2) begin
            n_err++;
            $display("FAIL midreset_pre: cnt=%0d expected 2", cnt_a);
        end
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        n_vec++;
        if (ifa.Final_Data !== 32'h0 || ifa.Final_Data_Ready !== 1'b0 || cnt_a !== 2'd0) begin
            n_err++;
            $display("FAIL midreset_clear: data=%h rdy=%b cnt=%0d expected data=0 rdy=0 cnt=0",
                     ifa.Final_Data, ifa.Final_Data_Ready, cnt_a);
        end
        err_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, bytes[i], 1'b0);
            err_seen = err_seen | ep_a | et_a | ov_a;
        end
        n_vec++;
        if (ifa.Final_Data_Ready !== 1'b1 || ifa.Final_Data !== 32'h10203040 || err_seen !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_word: rdy=%b data=%h errs=%b expected rdy=1 data=10203040 errs=0",
                     ifa.Final_Data_Ready, ifa.Final_Data, err_seen);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clr = 1'b1;
        ifa.Data_Rx = 8'h0; ifa.Data_Ready = 1'b0; ifa.parity_err = 1'b0; ifa.Final_Data_Ack = 1'b0;
        ifb.Data_Rx = 8'h0; ifb.Data_Ready = 1'b0; ifb.parity_err = 1'b0; ifb.Final_Data_Ack = 1'b0;
        #1;
        test_reset();
        test_normal_word();
        test_parity_drop();
        test_timeout();
        test_timeout_boundary();
        test_overrun();
        test_same_cycle_ack();
        test_ack_idle();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
